// File: rtl/uart_rx_deframe.sv
// -----------------------------------------------------------------------------
// uart_rx_deframe
//
// Downstream stage of the UART receiver, running on the system clock. It
// brings the baud-domain frame-done flag across with a flop synchronizer and
// captures the 11-bit frame on each rising edge of that flag. It then checks
// the start, stop and parity bits and presents the byte over a valid/ready
// handshake.
//
// Ports:
//   clock          system clock (at least 4x baud_clk)
//   reset          synchronous, active-high reset
//   data_parll     frame: [10]=start, [9:2]=data bits 0..7 reversed,
//                  [1]=parity, [0]=stop
//   recieved_flag  high while a complete frame is on data_parll (baud domain)
//   parity_type    00/11 none, 01 odd, 10 even; sampled at capture
//   data_ready     consumer accepts data_out this cycle
//   clear_errors   pulse: clears overrun_error and error_count
//   data_out       received byte
//   data_valid     data_out and the per-frame flags are valid
//   parity_error   parity mismatch for the presented frame
//   start_error    start bit was 1 for the presented frame
//   stop_error     stop bit was 0 for the presented frame
//   overrun_error  sticky: a frame was dropped while the previous one was held
//   error_count    saturating count of frames with any framing/parity error
// -----------------------------------------------------------------------------
module uart_rx_deframe #(
  parameter int SYNC_STAGES   = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [10:0]              data_parll,
  input  logic                     recieved_flag,
  input  logic [1:0]               parity_type,
  input  logic                     data_ready,
  input  logic                     clear_errors,
  output logic [7:0]               data_out,
  output logic                     data_valid,
  output logic                     parity_error,
  output logic                     start_error,
  output logic                     stop_error,
  output logic                     overrun_error,
  output logic [ERR_CNT_WIDTH-1:0] error_count
);

  typedef enum logic [1:0] {IDLE, CHECK, HOLD} state_t;

  state_t                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q, sync_d;
  logic                     prev_q, prev_d;
  logic [10:0]              frame_q, frame_d;
  logic [1:0]               ptype_q, ptype_d;
  logic [7:0]               data_out_q, data_out_d;
  logic                     valid_q, valid_d;
  logic                     pe_q, pe_d;
  logic                     se_q, se_d;
  logic                     st_q, st_d;
  logic                     ovr_q, ovr_d;
  logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic       sync_out;
  logic       new_frame;
  logic [7:0] data_w;
  logic       par_w;
  logic       pe_w;
  logic       se_w;
  logic       st_w;
  logic       transfer;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign new_frame = sync_out & ~prev_q;
  assign transfer  = valid_q & data_ready;

  // The shift register delivers data bit 0 at position 9, so reverse [9:2].
  always_comb begin
    for (int i = 0; i < 8; i++) data_w[i] = frame_q[9-i];
  end

  assign par_w = ^{data_w, frame_q[1]};
  assign se_w  = frame_q[10];
  assign st_w  = ~frame_q[0];

  always_comb begin
    unique case (ptype_q)
      2'b01:   pe_w = ~par_w;  // odd: total ones count must be odd
      2'b10:   pe_w = par_w;   // even: total ones count must be even
      default: pe_w = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts as its _q, so no path leaves a signal unassigned
    // and no latch is inferred.
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], recieved_flag};
    prev_d     = sync_out;
    frame_d    = frame_q;
    ptype_d    = ptype_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    pe_d       = pe_q;
    se_d       = se_q;
    st_d       = st_q;
    ovr_d      = ovr_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (new_frame) begin
          frame_d = data_parll;
          ptype_d = parity_type;
          state_d = CHECK;
        end
      end
      CHECK: begin
        data_out_d = data_w;
        pe_d       = pe_w;
        se_d       = se_w;
        st_d       = st_w;
        valid_d    = 1'b1;
        state_d    = HOLD;
        if ((pe_w | se_w | st_w) && (cnt_q != '1))
          cnt_d = cnt_q + ERR_CNT_WIDTH'(1);
        // The checker is busy for this single cycle; a new frame is lost.
        if (new_frame) ovr_d = 1'b1;
      end
      HOLD: begin
        if (transfer) begin
          valid_d = 1'b0;
          if (new_frame) begin
            frame_d = data_parll;
            ptype_d = parity_type;
            state_d = CHECK;
          end else begin
            state_d = IDLE;
          end
        end else if (new_frame) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clearing wins over a same-cycle increment or overrun.
    if (clear_errors) begin
      ovr_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      // Synchronizer and edge detector come up "high" so a flag already
      // asserted through reset does not look like a fresh edge.
      sync_q     <= '1;
      prev_q     <= 1'b1;
      // NOTE: the capture registers are reset too; they are a handful of
      // flops, not a memory, and a known value keeps simulation clean.
      frame_q    <= '0;
      ptype_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      st_q       <= 1'b0;
      ovr_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      frame_q    <= frame_d;
      ptype_q    <= ptype_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
      st_q       <= st_d;
      ovr_q      <= ovr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = valid_q;
  assign parity_error  = pe_q;
  assign start_error   = se_q;
  assign stop_error    = st_q;
  assign overrun_error = ovr_q;
  assign error_count   = cnt_q;

endmodule

// File: tb/tb_uart_rx_deframe.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deframe
//
// Directed bench for uart_rx_deframe. Inputs change 1 time unit after each
// rising clock edge and outputs are sampled at the same point, so every
// sample sees settled values from the preceding edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_deframe;

  localparam int SYNC_STAGES   = 2;
  localparam int ERR_CNT_WIDTH = 8;

  logic                     clock = 1'b0;
  logic                     reset;
  logic [10:0]              data_parll;
  logic                     recieved_flag;
  logic [1:0]               parity_type;
  logic                     data_ready;
  logic                     clear_errors;
  logic [7:0]               data_out;
  logic                     data_valid;
  logic                     parity_error;
  logic                     start_error;
  logic                     stop_error;
  logic                     overrun_error;
  logic [ERR_CNT_WIDTH-1:0] error_count;

  int checks   = 0;
  int failures = 0;

  uart_rx_deframe #(
    .SYNC_STAGES   (SYNC_STAGES),
    .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .data_parll    (data_parll),
    .recieved_flag (recieved_flag),
    .parity_type   (parity_type),
    .data_ready    (data_ready),
    .clear_errors  (clear_errors),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .start_error   (start_error),
    .stop_error    (stop_error),
    .overrun_error (overrun_error),
    .error_count   (error_count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Flag high for 8 clocks, then low for 4 so the synchronizer settles low.
  task automatic send_raw(input logic [10:0] frame, input logic [1:0] ptype);
    data_parll    = frame;
    parity_type   = ptype;
    recieved_flag = 1'b1;
    repeat (8) tick();
    recieved_flag = 1'b0;
    repeat (4) tick();
  endtask

  // One frame with data_ready=1: valid must appear exactly SYNC_STAGES+2
  // edges after the flag rises and last one cycle.
  task automatic frame_and_check(input string tag, input logic [10:0] frame,
                                 input logic [1:0] ptype, input logic [7:0] exp_data,
                                 input logic exp_pe, input logic exp_se,
                                 input logic exp_st, input int exp_cnt);
    data_parll    = frame;
    parity_type   = ptype;
    recieved_flag = 1'b1;
    repeat (SYNC_STAGES + 1) tick();
    check({tag, " valid_early"}, 32'(data_valid), 0);
    tick();
    check({tag, " valid"},    32'(data_valid),   1);
    check({tag, " data"},     32'(data_out),     32'(exp_data));
    check({tag, " parity"},   32'(parity_error), 32'(exp_pe));
    check({tag, " start"},    32'(start_error),  32'(exp_se));
    check({tag, " stop"},     32'(stop_error),   32'(exp_st));
    check({tag, " count"},    32'(error_count),  32'(exp_cnt));
    tick();
    check({tag, " valid_one_cycle"}, 32'(data_valid), 0);
    repeat (8 - (SYNC_STAGES + 3)) tick();
    recieved_flag = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset         = 1'b1;
    data_parll    = '0;
    recieved_flag = 1'b0;
    parity_type   = 2'b00;
    data_ready    = 1'b1;
    clear_errors  = 1'b0;
    repeat (3) tick();
    check("rst valid",   32'(data_valid),    0);
    check("rst data",    32'(data_out),      0);
    check("rst overrun", 32'(overrun_error), 0);
    check("rst count",   32'(error_count),   0);
    reset = 1'b0;
    repeat (4) tick();

    // Even parity, clean frame: 0x295 -> 0xA5.
    frame_and_check("even_ok", 11'h295, 2'b10, 8'hA5, 0, 0, 0, 0);
    // Same frame under odd parity is a parity error.
    frame_and_check("odd_bad", 11'h295, 2'b01, 8'hA5, 1, 0, 0, 1);
    frame_and_check("even_01", 11'h203, 2'b10, 8'h01, 0, 0, 0, 1);
    // No-parity setting (11) ignores the parity bit.
    frame_and_check("nopar",   11'h297, 2'b11, 8'hA5, 0, 0, 0, 1);
    // Start and stop errors.
    frame_and_check("start",   11'h695, 2'b10, 8'hA5, 0, 1, 0, 2);
    frame_and_check("stop",    11'h294, 2'b10, 8'hA5, 0, 0, 1, 3);

    // Drive the counter to 254, then across saturation.
    for (int i = 0; i < 251; i++) send_raw(11'h294, 2'b00);
    check("cnt_254", 32'(error_count), 254);
    frame_and_check("sat_255", 11'h294, 2'b00, 8'hA5, 0, 0, 1, 255);
    frame_and_check("sat_hold", 11'h695, 2'b00, 8'hA5, 0, 1, 0, 255);

    // Overrun: hold frame A unconsumed, then send frame B.
    data_ready = 1'b0;
    send_raw(11'h295, 2'b10);
    check("hold valid",   32'(data_valid),    1);
    check("hold data",    32'(data_out),      32'hA5);
    check("hold overrun", 32'(overrun_error), 0);
    send_raw(11'h203, 2'b10);
    check("ovr valid",   32'(data_valid),    1);
    check("ovr data",    32'(data_out),      32'hA5);
    check("ovr flag",    32'(overrun_error), 1);
    check("ovr count",   32'(error_count),   255);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    check("clr overrun", 32'(overrun_error), 0);
    check("clr count",   32'(error_count),   0);
    check("clr valid",   32'(data_valid),    1);
    check("clr data",    32'(data_out),      32'hA5);

    // Transfer and new_frame in the same cycle: new frame goes straight to CHECK.
    data_parll    = 11'h203;
    parity_type   = 2'b10;
    recieved_flag = 1'b1;
    repeat (SYNC_STAGES) tick();
    data_ready = 1'b1;  // new_frame is high in this cycle
    tick();
    check("b2b gap",    32'(data_valid), 0);
    tick();
    check("b2b valid",  32'(data_valid), 1);
    check("b2b data",   32'(data_out),   32'h01);
    check("b2b parity", 32'(parity_error), 0);
    check("b2b ovr",    32'(overrun_error), 0);
    repeat (8 - (SYNC_STAGES + 2)) tick();
    recieved_flag = 1'b0;
    repeat (4) tick();

    // Flag held high across reset: must not be captured.
    data_parll    = 11'h295;
    parity_type   = 2'b10;
    recieved_flag = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rst_flag no_valid", 32'(data_valid), 0);
    end
    recieved_flag = 1'b0;
    repeat (4) tick();
    frame_and_check("after_rst", 11'h295, 2'b10, 8'hA5, 0, 0, 0, 0);

    // Reset during HOLD discards the held frame.
    data_ready = 1'b0;
    send_raw(11'h203, 2'b10);
    check("hold2 valid", 32'(data_valid), 1);
    check("hold2 data",  32'(data_out),   32'h01);
    reset = 1'b1;
    tick();
    check("rst_hold valid", 32'(data_valid), 0);
    check("rst_hold data",  32'(data_out),   0);
    reset      = 1'b0;
    data_ready = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
